// File: rtl/sw_array_sequencer_pkg.sv
// Shared types for the Smith-Waterman array sequencer: base/score widths and sequencer states.
package sw_array_sequencer_pkg;

  localparam int unsigned SeqW   = 2;
  localparam int unsigned ScoreW = 10;

  typedef logic [SeqW-1:0]          seq_base_t;
  typedef logic signed [ScoreW-1:0] score_t;

  localparam seq_base_t BaseA = 2'd0;
  localparam seq_base_t BaseC = 2'd1;
  localparam seq_base_t BaseG = 2'd2;
  localparam seq_base_t BaseT = 2'd3;

  typedef enum logic [2:0] {SQ_IDLE, SQ_FETCH, SQ_STREAM, SQ_FLUSH, SQ_DONE} seq_state_t;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_phase_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module sw_phase_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/sw_array_sequencer.sv
// Runs one Smith-Waterman pass: fetches seq2 bases from RAM, streams them into the PE chain,
// flushes the chain and captures the best score/location from the chain tail.
module sw_array_sequencer
  import sw_array_sequencer_pkg::*;
#(
  parameter int unsigned LEN1 = 5,
  parameter int unsigned LEN2 = 5,
  localparam int unsigned ColW = $clog2(LEN2) + 1,
  localparam int unsigned RowW = $clog2(LEN1) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [ColW-1:0] db_len,
  output logic            busy,
  output logic            seq2_rd_en,
  output logic [ColW-1:0] seq2_addr,
  input  seq_base_t       seq2_rd_data,
  output logic            pe_enable,
  output logic            pe_valid_col,
  output seq_base_t       pe_seq2,
  output logic [ColW-1:0] pe_col_id,
  input  score_t          tail_max_h,
  input  logic [RowW-1:0] tail_max_row,
  input  logic [ColW-1:0] tail_max_col,
  output logic            result_valid,
  output score_t          result_score,
  output logic [RowW-1:0] result_row,
  output logic [ColW-1:0] result_col
);

  localparam int unsigned CntW = max_w(ColW, RowW);

  seq_state_t      state_q, state_d;
  logic [ColW-1:0] db_len_q, db_len_sat;
  logic            cnt_load, cnt_zero;
  logic [CntW-1:0] cnt_load_val, cnt;
  logic [ColW-1:0] col_next;

  assign db_len_sat = (db_len > ColW'(LEN2)) ? ColW'(LEN2) : db_len;
  // Counter runs db_len-1 .. 0 during STREAM, so (db_len - cnt) is the 1-based column k+1.
  assign col_next   = ColW'(CntW'(db_len_q) - cnt);

  sw_phase_counter #(
    .Width (CntW)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SQ_IDLE;
      db_len_q     <= '0;
      result_score <= '0;
      result_row   <= '0;
      result_col   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SQ_IDLE && start && !abort) begin
        db_len_q <= db_len_sat;
      end
      // DONE is only entered from FETCH (empty pass) or from the last FLUSH cycle.
      if (state_d == SQ_DONE) begin
        if (state_q == SQ_FETCH) begin
          result_score <= '0;
          result_row   <= '0;
          result_col   <= '0;
        end else begin
          result_score <= tail_max_h;
          result_row   <= tail_max_row;
          result_col   <= tail_max_col;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      SQ_IDLE: begin
        if (start && !abort) state_d = SQ_FETCH;
      end
      SQ_FETCH: begin
        if (db_len_q == '0) begin
          state_d = SQ_DONE;
        end else begin
          state_d      = SQ_STREAM;
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(db_len_q) - CntW'(1);
        end
      end
      SQ_STREAM: begin
        if (cnt_zero) begin
          state_d      = SQ_FLUSH;
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(LEN1 - 1);
        end
      end
      SQ_FLUSH: begin
        if (cnt_zero) state_d = SQ_DONE;
      end
      SQ_DONE: state_d = SQ_IDLE;
      default: state_d = SQ_IDLE;
    endcase
    if (abort && state_q != SQ_IDLE) begin
      state_d  = SQ_IDLE;
      cnt_load = 1'b0;
    end
  end

  always_comb begin
    busy         = (state_q != SQ_IDLE);
    seq2_rd_en   = 1'b0;
    seq2_addr    = '0;
    pe_enable    = 1'b0;
    pe_valid_col = 1'b0;
    pe_seq2      = '0;
    pe_col_id    = '0;
    result_valid = 1'b0;
    case (state_q)
      SQ_FETCH: begin
        seq2_rd_en = 1'b1;
      end
      SQ_STREAM: begin
        pe_enable    = 1'b1;
        pe_valid_col = 1'b1;
        pe_seq2      = seq2_rd_data;
        pe_col_id    = col_next;
        seq2_rd_en   = !cnt_zero;
        seq2_addr    = col_next;
      end
      SQ_FLUSH: pe_enable = 1'b1;
      SQ_DONE:  result_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sw_array_sequencer.sv
// Bench for sw_array_sequencer: cycle-indexed pass model plus directed passes with literal checks.
module tb_sw_array_sequencer;
  import sw_array_sequencer_pkg::*;

  localparam int LEN1 = 5;
  localparam int LEN2 = 8;

  logic        clk, rst, start, abort;
  logic [3:0]  db_len, seq2_addr, pe_col_id, tail_max_row, tail_max_col, result_row, result_col;
  logic        busy, seq2_rd_en, pe_enable, pe_valid_col, result_valid;
  seq_base_t   seq2_rd_data, pe_seq2, rd_q;
  score_t      tail_max_h, result_score;
  logic [32:0] act_vec;

  seq_base_t ram [8];
  int n_cmp = 0;
  int n_bad = 0;

  // Pass model: m_t counts cycles since the accepted start edge (0 = fetch cycle).
  bit m_active = 0;
  int m_t = 0, m_n = 0, m_score = 0, m_row = 0, m_col = 0;
  int stub_h = 0, stub_r = 0, stub_c = 0;

  sw_array_sequencer #(
    .LEN1 (LEN1),
    .LEN2 (LEN2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .db_len       (db_len),
    .busy         (busy),
    .seq2_rd_en   (seq2_rd_en),
    .seq2_addr    (seq2_addr),
    .seq2_rd_data (seq2_rd_data),
    .pe_enable    (pe_enable),
    .pe_valid_col (pe_valid_col),
    .pe_seq2      (pe_seq2),
    .pe_col_id    (pe_col_id),
    .tail_max_h   (tail_max_h),
    .tail_max_row (tail_max_row),
    .tail_max_col (tail_max_col),
    .result_valid (result_valid),
    .result_score (result_score),
    .result_row   (result_row),
    .result_col   (result_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (seq2_rd_en) rd_q <= ram[seq2_addr[2:0]];
  assign seq2_rd_data = rd_q;

  assign act_vec = {busy, seq2_rd_en, seq2_addr, pe_enable, pe_valid_col, pe_seq2, pe_col_id,
                    result_valid, result_score, result_row, result_col};

  function automatic int done_t(input int n);
    return (n == 0) ? 1 : n + LEN1 + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 0; m_t = 0; m_score = 0; m_row = 0; m_col = 0;
      end else if (!m_active) begin
        if (start && !abort) begin
          m_active = 1; m_t = 0; m_n = (int'(db_len) > LEN2) ? LEN2 : int'(db_len);
        end
      end else if (abort || m_t == done_t(m_n)) begin
        m_active = 0;
      end else begin
        m_t++;
        if (m_t == done_t(m_n)) begin
          m_score = (m_n == 0) ? 0 : int'(tail_max_h);
          m_row   = (m_n == 0) ? 0 : int'(tail_max_row);
          m_col   = (m_n == 0) ? 0 : int'(tail_max_col);
        end
      end
    end
  end

  // Tail stub: the real answer is visible only in the final flush cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_active && m_n > 0 && m_t == m_n + LEN1) begin
        tail_max_h = score_t'(stub_h); tail_max_row = 4'(stub_r); tail_max_col = 4'(stub_c);
      end else begin
        tail_max_h = score_t'(1); tail_max_row = 4'd1; tail_max_col = 4'd1;
      end
    end
  end

  initial begin
    logic [32:0] e;
    bit re, pe, vc, rv;
    int addr, cid, k;
    seq_base_t s2;
    forever begin
      @(negedge clk);
      re = 0; pe = 0; vc = 0; rv = 0; addr = 0; cid = 0; s2 = '0;
      if (m_active) begin
        if (m_t == 0) begin
          re = 1;
        end else if (m_n > 0 && m_t <= m_n) begin
          k = m_t - 1; pe = 1; vc = 1; s2 = ram[k]; cid = k + 1; re = (k + 1 < m_n); addr = k + 1;
        end else if (m_n > 0 && m_t <= m_n + LEN1) begin
          pe = 1;
        end else begin
          rv = 1;
        end
      end
      e = {m_active, re, 4'(addr), pe, vc, s2, 4'(cid), rv, score_t'(m_score), 4'(m_row),
           4'(m_col)};
      n_cmp++;
      if (act_vec !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs @%0t: got %0h expected %0h", $time, act_vec, e);
      end
    end
  end

  // poke_kind: 1 = start while busy, 2 = abort, 3 = async reset.
  task automatic run(input int len, input int poke_cyc, input int poke_kind, output int pe_cnt,
                     output int rv_at, output logic [51:0] col_vec, output logic [15:0] seq_vec);
    pe_cnt = 0; rv_at = 0; col_vec = '0; seq_vec = '0;
    @(posedge clk); #1;
    db_len = 4'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (pe_enable) begin
        pe_cnt++;
        col_vec = {col_vec[47:0], pe_col_id};
      end
      if (pe_valid_col) seq_vec = {seq_vec[13:0], pe_seq2};
      if (result_valid && rv_at == 0) rv_at = cyc;
      if (cyc == poke_cyc) begin
        #2;
        case (poke_kind)
          1: begin start = 1'b1; db_len = 4'd2; end
          2: abort = 1'b1;
          3: begin rst = 1'b0; #1; check("reset_async", 64'(act_vec), 64'd0); end
          default: ;
        endcase
      end else if (cyc == poke_cyc + 1) begin
        #2;
        start = 1'b0; abort = 1'b0; rst = 1'b1;
      end
    end
  endtask

  initial begin
    int pe_cnt, rv_at;
    logic [51:0] col_vec;
    logic [15:0] seq_vec;
    ram[0] = BaseA; ram[1] = BaseC; ram[2] = BaseG; ram[3] = BaseT;
    ram[4] = BaseA; ram[5] = BaseC; ram[6] = BaseG; ram[7] = BaseT;
    rst = 1'b0; start = 1'b0; abort = 1'b0; db_len = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(act_vec), 64'd0);
    #2 rst = 1'b1;

    stub_h = 7; stub_r = 3; stub_c = 6;
    run(8, 0, 0, pe_cnt, rv_at, col_vec, seq_vec);
    check("full_pe_cycles", 64'(pe_cnt), 64'd13);
    check("full_latency", 64'(rv_at), 64'd15);
    check("full_col_ids", 64'(col_vec), 64'h1234567800000);
    check("full_base_order", 64'(seq_vec), 64'h1B1B);
    check("full_result", 64'({result_score, result_row, result_col}), 64'({10'd7, 4'd3, 4'd6}));

    run(0, 0, 0, pe_cnt, rv_at, col_vec, seq_vec);
    check("empty_pe_cycles", 64'(pe_cnt), 64'd0);
    check("empty_latency", 64'(rv_at), 64'd2);
    check("empty_result", 64'({result_score, result_row, result_col}), 64'd0);

    run(8, 5, 2, pe_cnt, rv_at, col_vec, seq_vec);
    check("abort_pe_cycles", 64'(pe_cnt), 64'd4);
    check("abort_no_valid", 64'(rv_at), 64'd0);
    check("abort_result_kept", 64'({result_score, result_row, result_col}), 64'd0);

    stub_h = 5; stub_r = 2; stub_c = 8;
    run(12, 4, 1, pe_cnt, rv_at, col_vec, seq_vec);
    check("sat_pe_cycles", 64'(pe_cnt), 64'd13);
    check("sat_latency", 64'(rv_at), 64'd15);
    check("sat_result", 64'({result_score, result_row, result_col}), 64'({10'd5, 4'd2, 4'd8}));

    run(3, 6, 3, pe_cnt, rv_at, col_vec, seq_vec);
    check("reset_pe_cycles", 64'(pe_cnt), 64'd5);
    check("reset_no_valid", 64'(rv_at), 64'd0);

    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; db_len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", 64'(busy), 64'd0);

    stub_h = 11; stub_r = 2; stub_c = 1;
    run(2, 0, 0, pe_cnt, rv_at, col_vec, seq_vec);
    check("short_pe_cycles", 64'(pe_cnt), 64'd7);
    check("short_latency", 64'(rv_at), 64'd9);
    check("short_result", 64'({result_score, result_row, result_col}), 64'({10'd11, 4'd2, 4'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
